// File: rtl/nios_wallet_mem_copy_master_if.sv
// Control and Avalon-MM bus bundle for nios_wallet_mem_copy_master.
// The optional checksum output is present only when MEM_COPY_CHECKSUM_EN is defined.
interface nios_wallet_mem_copy_master_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LEN_W  = 13
);
  // control side
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              err;
  // RAM side
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  modport master (
    input  start, src_addr, dst_addr, length, readdata,
    output busy, done, err, address, chipselect, write, writedata, byteenable
`ifdef MEM_COPY_CHECKSUM_EN
    , output checksum
`endif
  );

  modport slave (
    output start, src_addr, dst_addr, length, readdata,
    input  busy, done, err, address, chipselect, write, writedata, byteenable
`ifdef MEM_COPY_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/nios_wallet_mem_copy_master.sv
// Avalon-MM block-copy master for the single-port on-chip RAM.
// Copies one 32-bit word at a time: read request, READ_LATENCY wait cycles, write.
// Optional feature macro: MEM_COPY_CHECKSUM_EN adds a modulo-2^32 sum of copied words.
module nios_wallet_mem_copy_master #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DEPTH        = 6500,
  parameter int unsigned LEN_W        = 13,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  nios_wallet_mem_copy_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    FIN
  } state_t;

  localparam int unsigned SUM_W  = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  localparam int unsigned WAIT_W = 3;

  state_t            state;
  state_t            next_state;

  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [31:0]       data_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;

  logic [SUM_W-1:0]  src_end;
  logic [SUM_W-1:0]  dst_end;
  logic              range_bad;
  logic              accept;
  logic              reject;
  logic              capture;
  logic              step;

  logic              cs;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  // Range sums are one bit wider than the operands so they cannot wrap.
  assign src_end   = SUM_W'(bus.src_addr) + SUM_W'(bus.length);
  assign dst_end   = SUM_W'(bus.dst_addr) + SUM_W'(bus.length);
  assign range_bad = (src_end > SUM_W'(DEPTH)) || (dst_end > SUM_W'(DEPTH));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    capture    = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            accept     = 1'b1;
            next_state = FIN;
          end else if (range_bad) begin
            reject     = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = RD_REQ;
          end
        end
      end
      RD_REQ:  next_state = RD_WAIT;
      RD_WAIT: begin
        if (wait_cnt == '0) begin
          capture    = 1'b1;
          next_state = WR;
        end
      end
      WR: begin
        step       = 1'b1;
        next_state = (remaining == LEN_W'(1)) ? FIN : RD_REQ;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pointers, word counter, read-wait counter, captured data and err pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_q    <= '0;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        src_ptr   <= bus.src_addr;
        dst_ptr   <= bus.dst_addr;
        remaining <= bus.length;
      end
      if (state == RD_REQ)
        wait_cnt <= WAIT_W'(READ_LATENCY - 1);
      else if (state == RD_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      if (capture)
        data_q <= bus.readdata;
      if (step) begin
        src_ptr   <= src_ptr + 1'b1;
        dst_ptr   <= dst_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Bus drive; reset suppresses the access in the same cycle so an in-flight
  // write is never committed on the edge that aborts the copy.
  always_comb begin
    cs    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    case (state)
      RD_REQ: begin
        cs   = 1'b1;
        addr = src_ptr;
      end
      WR: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = dst_ptr;
        wdata = data_q;
      end
      default: ;
    endcase
    if (reset) begin
      cs    = 1'b0;
      wr    = 1'b0;
      addr  = '0;
      wdata = '0;
    end
  end

  assign bus.chipselect = cs;
  assign bus.write      = wr;
  assign bus.address    = addr;
  assign bus.writedata  = wdata;
  assign bus.byteenable = cs ? 4'hF : 4'h0;
  assign bus.busy       = (state == RD_REQ) || (state == RD_WAIT) || (state == WR);
  assign bus.done       = (state == FIN);
  assign bus.err        = err_q;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running sum of captured words, cleared on each accepted start.
  always_ff @(posedge clk) begin
    if (reset)        checksum_q <= '0;
    else if (accept)  checksum_q <= '0;
    else if (capture) checksum_q <= checksum_q + bus.readdata;
  end

  assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_nios_wallet_mem_copy_master.sv
// Self-checking bench for nios_wallet_mem_copy_master with a behavioural RAM
// and a word-level reference copy model.
module tb_nios_wallet_mem_copy_master;
  parameter int unsigned RL = 1;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DEPTH  = 6500;
  localparam int unsigned LEN_W  = 13;
  localparam int unsigned TMO    = 400;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  nios_wallet_mem_copy_master_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  nios_wallet_mem_copy_master #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM model with RL-cycle read pipeline; garbage outside valid slots.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] pipe [0:3];
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, cs_cnt = 0;

  always @(posedge clk) begin
    for (int k = 3; k > 0; k--) pipe[k] <= pipe[k-1];
    if (bus.chipselect && !bus.write) pipe[0] <= mem[bus.address];
    else                              pipe[0] <= 32'hBADBAD00;
    if (bus.chipselect && bus.write) begin
      mem[bus.address] <= bus.writedata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.chipselect) cs_cnt <= cs_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.err)  err_cnt  <= err_cnt + 1;
  end
  assign bus.readdata = pipe[RL-1];

  task automatic clear_counts();
    @(posedge clk); #1;
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; cs_cnt = 0;
  endtask

  // Reference: ascending word copy; returns sum of words read.
  task automatic model_copy(input int src, input int dst, input int len, output logic [31:0] sum);
    sum = '0;
    for (int i = 0; i < len; i++) begin
      sum = sum + ref_mem[src+i];
      ref_mem[dst+i] = ref_mem[src+i];
    end
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Issue one start and wait for done; cyc is the cycle of done relative to start.
  task automatic run_copy(input int src, input int dst, input int len,
                          output int cyc, output bit busy_ok);
    bus.start = 1'b1; bus.src_addr = ADDR_W'(src); bus.dst_addr = ADDR_W'(dst);
    bus.length = LEN_W'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < TMO) begin
      if (bus.busy !== ((len != 0) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic check_region(input string nm, input int dst, input int len);
    for (int i = 0; i < len; i++) begin
      n_cmp++;
      if (mem[dst+i] !== ref_mem[dst+i]) begin
        n_fail++;
        $display("FAIL %s: mem[%0d] got %h want %h", nm, dst+i, mem[dst+i], ref_mem[dst+i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.chipselect !== 1'b0 || bus.write !== 1'b0) begin
      n_fail++; $display("FAIL reset_cs: got %b/%b want 0/0", bus.chipselect, bus.write); end
    n_cmp++; if (bus.address !== '0 || bus.writedata !== '0 || bus.byteenable !== 4'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h/%h/%h want 0", bus.address, bus.writedata, bus.byteenable); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; bit bok; logic [31:0] sum;
    for (int i = 0; i < 4; i++) poke(100+i, 32'(i+1));
    clear_counts();
    run_copy(100, 200, 4, cyc, bok);
    model_copy(100, 200, 4, sum);
    check_region("basic_data", 200, 4);
    n_cmp++; if (cyc != 1 + 4*(RL+2)) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", cyc, 1+4*(RL+2)); end
    n_cmp++; if (!bok) begin n_fail++; $display("FAIL basic_busy: got 0 want 1"); end
    @(posedge clk); #1;
    n_cmp++; if (wr_cnt != 4 || done_cnt != 1 || err_cnt != 0) begin
      n_fail++; $display("FAIL basic_counts: got wr=%0d done=%0d err=%0d want 4/1/0", wr_cnt, done_cnt, err_cnt); end
`ifdef MEM_COPY_CHECKSUM_EN
    n_cmp++; if (bus.checksum !== 32'd10) begin n_fail++; $display("FAIL basic_checksum: got %0d want 10", bus.checksum); end
`endif
  endtask

  task automatic test_len_zero();
    int cyc; bit bok;
    clear_counts();
    run_copy(5, 9, 0, cyc, bok);
    n_cmp++; if (cyc < 1 || cyc > 2) begin n_fail++; $display("FAIL zero_latency: got %0d want 1..2", cyc); end
    n_cmp++; if (!bok) begin n_fail++; $display("FAIL zero_busy: busy seen high"); end
    @(posedge clk); #1;
    n_cmp++; if (cs_cnt != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL zero_bus: got cs=%0d done=%0d want 0/1", cs_cnt, done_cnt); end
`ifdef MEM_COPY_CHECKSUM_EN
    n_cmp++; if (bus.checksum !== 32'd0) begin n_fail++; $display("FAIL zero_checksum: got %0d want 0", bus.checksum); end
`endif
  endtask

  task automatic try_reject(input string nm, input int src, input int dst, input int len);
    bit err1, busy_seen;
    clear_counts();
    bus.start = 1'b1; bus.src_addr = ADDR_W'(src); bus.dst_addr = ADDR_W'(dst); bus.length = LEN_W'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    err1 = bus.err; busy_seen = bus.busy;
    repeat (5) begin @(posedge clk); #1; if (bus.busy) busy_seen = 1'b1; end
    n_cmp++; if (err1 !== 1'b1 || err_cnt != 1 || cs_cnt != 0 || busy_seen || done_cnt != 0) begin
      n_fail++; $display("FAIL %s: got err1=%b errs=%0d cs=%0d busy=%b done=%0d want 1/1/0/0/0",
                         nm, err1, err_cnt, cs_cnt, busy_seen, done_cnt); end
  endtask

  task automatic test_range();
    int cyc; bit bok; logic [31:0] sum;
    try_reject("range_src", 6498, 0, 3);
    try_reject("range_dst", 0, 6498, 3);
    try_reject("range_big", 8000, 0, 8191);
    for (int i = 0; i < 3; i++) poke(6497+i, $urandom);
    clear_counts();
    run_copy(6497, 3000, 3, cyc, bok);
    model_copy(6497, 3000, 3, sum);
    check_region("range_edge_data", 3000, 3);
    n_cmp++; if (cyc != 1 + 3*(RL+2) || err_cnt != 0) begin
      n_fail++; $display("FAIL range_edge: got cyc=%0d err=%0d want %0d/0", cyc, err_cnt, 1+3*(RL+2)); end
  endtask

  task automatic test_ignore_start();
    int cyc; logic [31:0] sum;
    clear_counts();
    bus.start = 1'b1; bus.src_addr = 13'd400; bus.dst_addr = 13'd500; bus.length = 13'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.src_addr = 13'd700; bus.dst_addr = 13'd800; bus.length = 13'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < TMO) begin @(posedge clk); #1; cyc++; end
    repeat (10) @(posedge clk);
    #1;
    model_copy(400, 500, 8, sum);
    check_region("ignore_data", 500, 8);
    n_cmp++; if (wr_cnt != 8 || done_cnt != 1 || err_cnt != 0) begin
      n_fail++; $display("FAIL ignore_counts: got wr=%0d done=%0d err=%0d want 8/1/0", wr_cnt, done_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid();
    int seen, guard; logic [31:0] sum;
    for (int i = 0; i < 5; i++) begin poke(900+i, $urandom); poke(950+i, $urandom); end
    clear_counts();
    bus.start = 1'b1; bus.src_addr = 13'd900; bus.dst_addr = 13'd950; bus.length = 13'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 0; guard = 0;
    while (seen < 3 && guard < TMO) begin
      if (bus.chipselect && bus.write) seen++;
      if (seen < 3) begin @(posedge clk); #1; end
      guard++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.chipselect !== 1'b0 ||
                 bus.write !== 1'b0 || bus.address !== '0 || bus.writedata !== '0 || bus.byteenable !== 4'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got busy=%b done=%b cs=%b wr=%b addr=%h want all 0",
                         bus.busy, bus.done, bus.chipselect, bus.write, bus.address); end
    reset = 1'b0;
    model_copy(900, 950, 2, sum);
    check_region("midreset_data", 950, 5);
    n_cmp++; if (wr_cnt != 2) begin n_fail++; $display("FAIL midreset_writes: got %0d want 2", wr_cnt); end
  endtask

  task automatic test_overlap();
    int cyc; bit bok; logic [31:0] sum;
    for (int i = 0; i < 4; i++) poke(10+i, $urandom);
    clear_counts();
    run_copy(10, 11, 3, cyc, bok);
    model_copy(10, 11, 3, sum);
    check_region("overlap_data", 10, 4);
    n_cmp++; if (mem[13] !== mem[10]) begin n_fail++; $display("FAIL overlap_replicate: got %h want %h", mem[13], mem[10]); end
    n_cmp++; if (cyc != 1 + 3*(RL+2)) begin n_fail++; $display("FAIL overlap_latency: got %0d want %0d", cyc, 1+3*(RL+2)); end
`ifdef MEM_COPY_CHECKSUM_EN
    n_cmp++; if (bus.checksum !== sum) begin n_fail++; $display("FAIL overlap_checksum: got %h want %h", bus.checksum, sum); end
`endif
  endtask

  task automatic test_random();
    int cyc, src, dst, len; bit bok; logic [31:0] sum;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 12);
      src = $urandom_range(1000, 2000);
      dst = (t % 2 == 0) ? src + $urandom_range(0, 14) - 7 : $urandom_range(3000, 4000);
      for (int i = 0; i < len; i++) poke(src+i, $urandom);
      clear_counts();
      run_copy(src, dst, len, cyc, bok);
      model_copy(src, dst, len, sum);
      check_region("random_data", dst, len);
      n_cmp++; if (cyc != 1 + len*(RL+2) || !bok) begin
        n_fail++; $display("FAIL random_timing: got cyc=%0d busy_ok=%b want %0d/1", cyc, bok, 1+len*(RL+2)); end
`ifdef MEM_COPY_CHECKSUM_EN
      n_cmp++; if (bus.checksum !== sum) begin n_fail++; $display("FAIL random_checksum: got %h want %h", bus.checksum, sum); end
`endif
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
    test_reset();
    test_basic();
    test_len_zero();
    test_range();
    test_ignore_start();
    test_reset_mid();
    test_overlap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
